// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Read-side sequencer between the TX async FIFO and UART_TX, both in the UART TX
// clock domain. It launches one byte at a time and pops the FIFO only after the
// frame has finished. The transmitter's TX_BUSY level is turned into a single
// TX_DATA_VALID strobe per launch and a single FIFO_RD_INC strobe per finished
// frame. If the transmitter never raises TX_BUSY after a launch, a timeout
// returns the sequencer to IDLE without popping, so the same head word is
// launched again later.

module uart_tx_feeder #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16, // must be at least 2
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,           // async assert, active-low
    input  logic                  TX_ENABLE,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic                  TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT
);

    // The timeout counter holds the number of cycles since the TX_DATA_VALID
    // cycle. Its largest value is TIMEOUT_CYCLES-1.
    localparam int unsigned        TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        POP       = 3'd4
    } state_e;

    state_e                state_q,     state_d;
    logic [TO_W-1:0]       to_cnt_q,    to_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  err_q,       err_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

    logic launch_ok;

    // A new frame may start only when enabled, data is waiting and the
    // transmitter is idle. This also blocks a launch while a frame that was
    // cut off by reset is still going out.
    assign launch_ok = TX_ENABLE && !FIFO_EMPTY && !TX_BUSY;

    // Next-state and next-register logic for the launch/pop sequencer.
    always_comb begin
        // NOTE: every variable driven here is given a default value first. No
        // path through the case can then leave one unassigned, so no latch is
        // inferred.
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        data_d      = data_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (launch_ok) begin
                    // Capture the head word on the IDLE->LAUNCH edge only.
                    // TX_P_DATA then holds it through the frame or a timeout.
                    data_d   = FIFO_RD_DATA;
                    // The counter is cleared on entry, so it reads zero during
                    // the LAUNCH (TX_DATA_VALID) cycle.
                    to_cnt_d = '0;
                    state_d  = LAUNCH;
                end
            end

            LAUNCH: begin
                to_cnt_d = to_cnt_q + 1'b1;
                state_d  = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    // The launch was not accepted. Do not pop: the same word is
                    // retried once IDLE sees the launch condition again.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                // Frame length belongs to UART_TX, so this state has no timeout.
                // TX_ENABLE is not looked at here, so a frame is never aborted.
                if (!TX_BUSY) begin
                    state_d = POP;
                end
            end

            POP: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any frame in flight
    // without popping it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the data register is reset along with the control state,
            // so TX_P_DATA reads 0 straight after reset and not a stale byte.
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the values it had before this edge, whatever the statement order.
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            data_q      <= data_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The strobes come only from state or from a register, never directly
    // from an input.
    assign TX_DATA_VALID = (state_q == LAUNCH);
    assign FIFO_RD_INC   = (state_q == POP);
    assign TIMEOUT_ERR   = err_q;
    assign TX_P_DATA     = data_q;
    assign FRAME_CNT     = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder. A FIFO model and a UART_TX model both run
// on the falling clock edge. The UART model raises busy in response to
// TX_DATA_VALID and holds it for busy_len cycles. The directed steps run at
// posedge+1.

module tb_uart_tx_feeder;

    localparam int DW = 8;
    localparam int TC = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          tx_enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_inc;
    logic          tx_busy;
    logic [DW-1:0] tx_p_data;
    logic          tx_data_valid;
    logic          timeout_err;
    logic [CW-1:0] frame_cnt;

    uart_tx_feeder #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TC),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .TX_ENABLE    (tx_enable),
        .FIFO_EMPTY   (fifo_empty),
        .FIFO_RD_DATA (fifo_rd_data),
        .FIFO_RD_INC  (fifo_rd_inc),
        .TX_BUSY      (tx_busy),
        .TX_P_DATA    (tx_p_data),
        .TX_DATA_VALID(tx_data_valid),
        .TIMEOUT_ERR  (timeout_err),
        .FRAME_CNT    (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state and event log.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] launched[$];
    int            valid_cycs[$];
    int            err_cycs[$];
    int            uart_en;
    int            busy_len;
    int            busy_left;
    int            cyc;
    int            n_valid;
    int            n_pop;
    int            n_err;
    int            overlap;
    int            fall_cyc;
    int            pop_cyc;

    int total = 0;
    int bad   = 0;

    // FIFO and UART_TX models. They sample the DUT on the falling edge and then
    // update its inputs.
    initial begin
        tx_busy      = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        uart_en      = 0;
        busy_len     = 10;
        busy_left    = 0;
        cyc          = 0;
        n_valid      = 0;
        n_pop        = 0;
        n_err        = 0;
        overlap      = 0;
        fall_cyc     = 0;
        pop_cyc      = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_data_valid && fifo_rd_inc) overlap++;
            if (tx_data_valid) begin
                n_valid++;
                launched.push_back(tx_p_data);
                valid_cycs.push_back(cyc);
            end
            if (fifo_rd_inc) begin
                n_pop++;
                pop_cyc = cyc;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            if (timeout_err) begin
                n_err++;
                err_cycs.push_back(cyc);
            end
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                end
            end
            if (tx_data_valid && uart_en != 0) begin
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end
            fifo_empty   = (fifo_q.size() == 0);
            fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        launched.delete();
        valid_cycs.delete();
        err_cycs.delete();
        n_valid = 0;
        n_pop   = 0;
        n_err   = 0;
        overlap = 0;
    endtask

    function automatic int count_of(input int which);
        case (which)
            0:       return n_pop;
            1:       return n_valid;
            default: return n_err;
        endcase
    endfunction

    // Wait until a log count (0 = pops, 1 = launches, 2 = timeouts) reaches n.
    // The wait is bounded by budget cycles.
    task automatic wait_count(input int which, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (count_of(which) < n && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_reached"}, 32'(count_of(which) >= n), 32'd1);
    endtask

    initial begin
        int start;
        int early;
        int k;

        rst_n     = 1'b0;
        tx_enable = 1'b0;
        tick(3);

        // Reset state.
        check("rst_valid", 32'(tx_data_valid), 32'd0);
        check("rst_pop",   32'(fifo_rd_inc),   32'd0);
        check("rst_err",   32'(timeout_err),   32'd0);
        check("rst_data",  32'(tx_p_data),     32'd0);
        check("rst_cnt",   32'(frame_cnt),     32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single byte 0xA5, busy held for 10 cycles.
        uart_en  = 1;
        busy_len = 10;
        fifo_q.push_back(8'hA5);
        tx_enable = 1'b1;
        start = cyc;
        wait_count(0, 1, 60, "t1_pop");
        tick(5);
        check("t1_nvalid",  32'(n_valid),             32'd1);
        check("t1_byte",    32'(launched[0]),         32'hA5);
        check("t1_latency", 32'(valid_cycs[0] - start), 32'd2);
        check("t1_poptime", 32'(pop_cyc - fall_cyc), 32'd1);
        check("t1_npop",    32'(n_pop),               32'd1);
        check("t1_cnt",     32'(frame_cnt),           32'd1);
        check("t1_empty",   32'(fifo_empty),          32'd1);
        check("t1_hold",    32'(tx_p_data),           32'hA5);

        // Burst 0x01..0x04 with 8-cycle frames. FRAME_CNT goes 1 -> 5.
        clear_log();
        busy_len = 8;
        for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
        wait_count(0, 4, 200, "t2_pop");
        tick(5);
        check("t2_nvalid", 32'(n_valid), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_order", 32'(launched[i]), 32'(i + 1));
        // valid(v) -> busy falls at v+8 -> POP at v+9 -> IDLE at v+10 -> LAUNCH at v+11.
        check("t2_spacing", 32'(valid_cycs[1] - valid_cycs[0]), 32'd11);
        check("t2_cnt",     32'(frame_cnt), 32'd5);
        check("t2_overlap", 32'(overlap),   32'd0);
        check("t2_noerr",   32'(n_err),     32'd0);

        // Timeout: busy never rises. Expect two timeouts on 0x3C and no pop.
        clear_log();
        uart_en = 0;
        fifo_q.push_back(8'h3C);
        wait_count(2, 2, 100, "t3_err");
        check("t3_to1",      32'(err_cycs[0] - valid_cycs[0]), 32'd16);
        check("t3_relaunch", 32'(valid_cycs[1] - err_cycs[0]), 32'd1);
        check("t3_to2",      32'(err_cycs[1] - valid_cycs[1]), 32'd16);
        check("t3_byte0",    32'(launched[0]), 32'h3C);
        check("t3_byte1",    32'(launched[1]), 32'h3C);
        check("t3_nopop",    32'(n_pop),       32'd0);
        check("t3_hold",     32'(tx_p_data),   32'h3C);
        uart_en  = 1;
        busy_len = 6;
        wait_count(0, 1, 100, "t3_drain");
        tick(3);
        check("t3_empty", 32'(fifo_empty), 32'd1);
        check("t3_cnt",   32'(frame_cnt),  32'd6);

        // TX_ENABLE dropped during WAIT_DONE with two bytes queued.
        clear_log();
        busy_len = 10;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        wait_count(1, 1, 40, "t4_launch");
        tick(4);
        tx_enable = 1'b0;
        wait_count(0, 1, 40, "t4_pop1");
        tick(20);
        check("t4_hold_nvalid", 32'(n_valid),    32'd1);
        check("t4_hold_npop",   32'(n_pop),      32'd1);
        check("t4_queued",      32'(fifo_empty), 32'd0);
        tx_enable = 1'b1;
        wait_count(0, 2, 60, "t4_pop2");
        tick(3);
        check("t4_byte1", 32'(launched[1]), 32'h22);
        check("t4_cnt",   32'(frame_cnt),   32'd8);

        // Reset during WAIT_DONE, with busy still high after release.
        clear_log();
        busy_len = 20;
        fifo_q.push_back(8'h5A);
        wait_count(1, 1, 40, "t5_launch");
        tick(4);
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(tx_data_valid), 32'd0);
        check("t5_pop",   32'(fifo_rd_inc),   32'd0);
        check("t5_err",   32'(timeout_err),   32'd0);
        check("t5_data",  32'(tx_p_data),     32'd0);
        check("t5_cnt",   32'(frame_cnt),     32'd0);
        tick(2);
        rst_n = 1'b1;
        early = 0;
        k = 0;
        while (tx_busy && k < 60) begin
            if (n_valid > 1) early++;
            tick(1);
            k++;
        end
        check("t5_busyfell", 32'(tx_busy), 32'd0);
        check("t5_nolaunch", 32'(early),   32'd0);
        check("t5_nopop",    32'(n_pop),   32'd0);
        wait_count(0, 1, 80, "t5_pop");
        tick(3);
        check("t5_byte",  32'(launched[1]), 32'h5A);
        check("t5_cnt2",  32'(frame_cnt),   32'd1);

        // Wrap: 257 frames from a cleared counter leave FRAME_CNT = 1.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        clear_log();
        busy_len = 2;
        for (int i = 0; i < 257; i++) fifo_q.push_back(8'(i));
        wait_count(0, 257, 5000, "t6_pop");
        tick(5);
        check("t6_cnt",     32'(frame_cnt),      32'd1);
        check("t6_nvalid",  32'(n_valid),        32'd257);
        check("t6_last",    32'(launched[256]),  32'h00);
        check("t6_overlap", 32'(overlap),        32'd0);
        check("t6_noerr",   32'(n_err),          32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
